// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_pkg
//  Description : Shared constants and entry type for the register writeback
//                queue. Also used by the forwarding lookup sub-module.
//                Contents:
//                  DATA_W     register data width
//                  ADDR_W     register address width (8 registers)
//                  WB_DEPTH   default number of buffered writebacks
//                  wb_entry_t one buffered request {add, data}
//  Revision    : 1.0  initial release
// ============================================================================
package reg_wb_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] add;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage : reg_wb_pkg
`default_nettype wire

// File: rtl/reg_wb_fwd_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_fwd_lookup
//  Description : Searches the pending writeback entries for a register
//                address and returns the youngest matching value.
//  Ports       : entries_i  circular buffer contents
//                valid_i    per-entry valid bits
//                tail_i     next write slot (youngest entry sits at tail-1)
//                add_i      lookup address
//                hit_o      some valid entry targets add_i
//                data_o     data of the youngest match, 0 when no hit
//  Revision    : 1.0  initial release
// ============================================================================
module reg_wb_fwd_lookup
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t         entries_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PTR_W-1:0]  tail_i,
    input  logic [ADDR_W-1:0] add_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (tail-DEPTH == tail) to youngest (tail-1); a later
    // match overrides an earlier one, giving youngest-match priority.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PTR_W'(k);
            if (valid_i[idx] && (entries_i[idx].add == add_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule : reg_wb_fwd_lookup
`default_nettype wire

// File: rtl/reg_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback_queue
//  Description : In-order writeback buffer in front of the register-file
//                write port. Accepts requests over valid/ready, drains one
//                per cycle unless rf_stall, and offers two forwarding
//                lookups over the pending entries.
//  Macro       : REG_WB_FORWARD_EN - when defined, fwd1_*/fwd2_* lookups are
//                built; otherwise fwd*_hit/fwd*_data are tied to 0.
//  Ports       : clk, rst (async, active-low)
//                in_valid/in_ready/in_add/in_data   request handshake
//                rf_stall                            blocks draining
//                write_EN/reg_write_add/reg_write_data  register-file write
//                fwdN_add -> fwdN_hit/fwdN_data      forwarding lookups
//                count                               occupied entries
//  Revision    : 1.0  initial release
// ============================================================================
module reg_writeback_queue
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_add,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rf_stall,
    output logic              write_EN,
    output logic [ADDR_W-1:0] reg_write_add,
    output logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] fwd1_add,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    input  logic [ADDR_W-1:0] fwd2_add,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data,
    output logic [CNT_W-1:0]  count
);

    wb_entry_t        entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Ready looks only at registered occupancy: a full queue refuses even
    // when the head drains this same cycle.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign write_EN = (count_q != '0) && !rf_stall;
    assign push     = in_valid && in_ready;
    assign pop      = write_EN;
    assign count    = count_q;

    // Head slot is valid exactly when the queue is non-empty.
    assign reg_write_add  = valid_q[head_q] ? entries_q[head_q].add  : '0;
    assign reg_write_data = valid_q[head_q] ? entries_q[head_q].data : '0;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; the valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tail_q].add  <= in_add;
            entries_q[tail_q].data <= in_data;
        end
    end

`ifdef REG_WB_FORWARD_EN
    reg_wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
        .entries_i (entries_q),
        .valid_i   (valid_q),
        .tail_i    (tail_q),
        .add_i     (fwd1_add),
        .hit_o     (fwd1_hit),
        .data_o    (fwd1_data)
    );

    reg_wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
        .entries_i (entries_q),
        .valid_i   (valid_q),
        .tail_i    (tail_q),
        .add_i     (fwd2_add),
        .hit_o     (fwd2_hit),
        .data_o    (fwd2_data)
    );
`else
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;

    // Lookup addresses are accepted but ignored in this build.
    logic unused_fwd_add;
    assign unused_fwd_add = ^{fwd1_add, fwd2_add};
`endif

endmodule : reg_writeback_queue
`default_nettype wire
